// File: rtl/divider.sv
// Multi-cycle radix-2 restoring divider with busy/done handshake and div-by-zero flag.
// Define DIVIDER_SIGNED_EN to honour is_signed (sign-magnitude wrap around the unsigned core).
module divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [1:0]       flag
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic             neg_q;
  logic             neg_r;
  logic             ovf;
  logic             dbz;

  logic             sgn;
`ifdef DIVIDER_SIGNED_EN
  assign sgn = is_signed;
`else
  logic unused_is_signed;
  assign sgn = 1'b0;
  assign unused_is_signed = is_signed;
`endif

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_comb begin
    a_neg  = sgn & A[WIDTH-1];
    b_neg  = sgn & B[WIDTH-1];
    a_mag  = a_neg ? (~A + WIDTH'(1)) : A;
    b_mag  = b_neg ? (~B + WIDTH'(1)) : B;
    // Dividend bits are shifted out of dvd's MSB while quotient bits enter at its LSB.
    rem_sh = {rem, dvd[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs};
    borrow = rem_sh < {1'b0, dvs};
    q_fix  = neg_q ? (~dvd + WIDTH'(1)) : dvd;
    r_fix  = neg_r ? (~rem + WIDTH'(1)) : rem;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      flag      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            flag  <= '0;
            cnt   <= CW'(WIDTH);
            rem   <= '0;
            dvs   <= b_mag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            ovf   <= sgn && (A == MIN_NEG) && (B == '1);
            if (B == '0) begin
              // Raw dividend is kept so the remainder can report it unchanged.
              dbz   <= 1'b1;
              dvd   <= A;
              state <= FIN;
            end else begin
              dbz   <= 1'b0;
              dvd   <= a_mag;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= borrow ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
          dvd <= {dvd[WIDTH-2:0], ~borrow};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIN;
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          if (dbz) begin
            quotient  <= '1;
            remainder <= dvd;
            flag      <= 2'b01;
          end else begin
            quotient  <= q_fix;
            remainder <= r_fix;
            flag      <= {ovf, 1'b0};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
module tb_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        is_signed;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic [1:0]  flag;

  int checks = 0;
  int errors = 0;

  divider #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .is_signed(is_signed),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .flag(flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int start_lat, output int lat);
    lat = start_lat;
    while (done !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $error("FAIL wait_done expired after %0d cycles without done", lat);
    end
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic s, output int lat);
    A = a; B = b; is_signed = s; start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_accept", busy, 1'b1);
    wait_done(0, lat);
    chk("busy_low_at_done", busy, 1'b0);
  endtask

  task automatic pulse_end();
    step();
    chk("done_pulse_width", done, 1'b0);
  endtask

  initial begin
    int lat;
    int seen;
    logic [15:0] ra, rb;
    logic [31:0] recon;

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; is_signed = 1'b0;
    step();
    step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_quotient", quotient, 16'h0000);
    chk("rst_remainder", remainder, 16'h0000);
    chk("rst_flag", flag, 2'b00);

    rst_n = 1'b1;
    run(16'd100, 16'd7, 1'b0, lat);
    chk("100/7 latency", lat, 17);
    chk("100/7 quotient", quotient, 16'd14);
    chk("100/7 remainder", remainder, 16'd2);
    chk("100/7 flag", flag, 2'b00);
    pulse_end();

    run(16'h1234, 16'h0000, 1'b0, lat);
    chk("div0 latency", lat, 1);
    chk("div0 quotient", quotient, 16'hFFFF);
    chk("div0 remainder", remainder, 16'h1234);
    chk("div0 flag", flag, 2'b01);
    pulse_end();

    A = 16'd50; B = 16'd5; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    A = 16'd9; B = 16'd3; start = 1'b1;
    step();
    start = 1'b0; A = '0; B = '0;
    wait_done(4, lat);
    chk("busy_start latency", lat, 17);
    chk("busy_start quotient", quotient, 16'd10);
    chk("busy_start remainder", remainder, 16'd0);
    pulse_end();
    step(); step(); step();
    chk("hold quotient", quotient, 16'd10);
    chk("hold flag", flag, 2'b00);

    A = 16'd1000; B = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int unsigned i = 0; i < 7; i++) step();
    rst_n = 1'b0;
    step();
    chk("midrst busy", busy, 1'b0);
    chk("midrst done", done, 1'b0);
    chk("midrst quotient", quotient, 16'h0000);
    chk("midrst remainder", remainder, 16'h0000);
    chk("midrst flag", flag, 2'b00);
    rst_n = 1'b1;
    seen = 0;
    for (int unsigned i = 0; i < 20; i++) begin
      step();
      if (done === 1'b1) seen++;
    end
    chk("midrst no done", seen, 0);
    run(16'd9, 16'd3, 1'b0, lat);
    chk("9/3 quotient", quotient, 16'd3);
    chk("9/3 remainder", remainder, 16'd0);
    pulse_end();

    run(16'hFFFF, 16'h0001, 1'b0, lat);
    chk("max/1 quotient", quotient, 16'hFFFF);
    chk("max/1 remainder", remainder, 16'h0000);
    run(16'd5, 16'd10, 1'b0, lat);
    chk("5/10 quotient", quotient, 16'h0000);
    chk("5/10 remainder", remainder, 16'd5);
    run(16'hFFFF, 16'hFFFF, 1'b0, lat);
    chk("max/max quotient", quotient, 16'h0001);
    chk("max/max remainder", remainder, 16'h0000);

    run(16'hFFF9, 16'h0002, 1'b1, lat);
    chk("s -7/2 latency", lat, 17);
`ifdef DIVIDER_SIGNED_EN
    chk("s -7/2 quotient", quotient, 16'hFFFD);
    chk("s -7/2 remainder", remainder, 16'hFFFF);
`else
    chk("s -7/2 quotient", quotient, 16'd32764);
    chk("s -7/2 remainder", remainder, 16'd1);
`endif
    chk("s -7/2 flag", flag, 2'b00);
    run(16'h8000, 16'hFFFF, 1'b1, lat);
    chk("ovf latency", lat, 17);
`ifdef DIVIDER_SIGNED_EN
    chk("ovf quotient", quotient, 16'h8000);
    chk("ovf remainder", remainder, 16'h0000);
    chk("ovf flag", flag, 2'b10);
`else
    chk("ovf quotient", quotient, 16'h0000);
    chk("ovf remainder", remainder, 16'h8000);
    chk("ovf flag", flag, 2'b00);
`endif
    pulse_end();

    for (int unsigned n = 0; n < 1000; n++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(1, 65535));
      run(ra, rb, 1'b0, lat);
      recon = 32'(quotient) * 32'(rb) + 32'(remainder);
      chk("rand latency", lat, 17);
      chk("rand reconstruct", recon, 32'(ra));
      chk("rand rem_lt_b", (remainder < rb), 1'b1);
      pulse_end();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
